// File: rtl/game_round_controller.sv
// Round sequencer for the shooter game: idle, four combat rounds, win.
// Owns the one-hot game state, per-round enemy alive mask, lives and the
// freeze pause that follows a round clear or a life loss.
module game_round_controller #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [3:0] enemy_hit,
    input  logic       player_hit,
    output logic       q_I,
    output logic       q_First,
    output logic       q_Second,
    output logic       q_Third,
    output logic       q_Final,
    output logic       q_Win,
    output logic [3:0] enemy_active,
    output logic       play_enable,
    output logic [1:0] lives,
    output logic       round_clear,
    output logic       life_lost,
    output logic       game_over
);

    localparam int unsigned NUM_ENEMIES = 4;
    localparam int unsigned LIVES_W     = 2;
    localparam int unsigned PAUSE_W     = 8;

    typedef enum logic [5:0] {
        ST_I      = 6'b000001,
        ST_FIRST  = 6'b000010,
        ST_SECOND = 6'b000100,
        ST_THIRD  = 6'b001000,
        ST_FINAL  = 6'b010000,
        ST_WIN    = 6'b100000
    } state_e;

    state_e                   state_q, state_d;
    logic [NUM_ENEMIES-1:0]   alive_q, alive_d;
    logic [NUM_ENEMIES-1:0]   enemy_active_q, enemy_active_d;
    logic                     play_enable_q, play_enable_d;
    logic [LIVES_W-1:0]       lives_q, lives_d;
    logic [PAUSE_W-1:0]       pause_cnt_q, pause_cnt_d;
    logic                     round_clear_q, round_clear_d;
    logic                     life_lost_q, life_lost_d;
    logic                     game_over_q, game_over_d;

    logic [NUM_ENEMIES-1:0]   alive_after_hit;
    logic [PAUSE_W-1:0]       pause_cnt_inc;
    logic                     pause_done;
    state_e                   next_round;

    function automatic logic [NUM_ENEMIES-1:0] round_mask(input state_e s);
        case (s)
            ST_FIRST:  round_mask = 4'b0001;
            ST_SECOND: round_mask = 4'b0010;
            ST_THIRD:  round_mask = 4'b1100;
            ST_FINAL:  round_mask = 4'b1111;
            default:   round_mask = 4'b0000;
        endcase
    endfunction

    // State, tracking and registered output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_I;
            alive_q        <= '0;
            enemy_active_q <= '0;
            play_enable_q  <= 1'b0;
            lives_q        <= '0;
            pause_cnt_q    <= '0;
            round_clear_q  <= 1'b0;
            life_lost_q    <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            alive_q        <= alive_d;
            enemy_active_q <= enemy_active_d;
            play_enable_q  <= play_enable_d;
            lives_q        <= lives_d;
            pause_cnt_q    <= pause_cnt_d;
            round_clear_q  <= round_clear_d;
            life_lost_q    <= life_lost_d;
            game_over_q    <= game_over_d;
        end
    end

    // Next-state, round progression, pause timing and life accounting
    always_comb begin
        state_d         = state_q;
        alive_d         = alive_q;
        play_enable_d   = play_enable_q;
        lives_d         = lives_q;
        pause_cnt_d     = pause_cnt_q;
        round_clear_d   = 1'b0;
        life_lost_d     = 1'b0;
        game_over_d     = game_over_q;
        pause_done      = 1'b0;
        alive_after_hit = alive_q & ~enemy_hit;
        pause_cnt_inc   = PAUSE_W'(pause_cnt_q + 1'b1);

        case (state_q)
            ST_FIRST:  next_round = ST_SECOND;
            ST_SECOND: next_round = ST_THIRD;
            ST_THIRD:  next_round = ST_FINAL;
            default:   next_round = ST_WIN;
        endcase

        case (state_q)
            ST_I: begin
                if (start) begin
                    state_d       = ST_FIRST;
                    lives_d       = LIVES_W'(LIVES);
                    alive_d       = round_mask(ST_FIRST);
                    play_enable_d = 1'b1;
                    game_over_d   = 1'b0;
                end
            end
            ST_WIN: begin
                if (start) begin
                    state_d = ST_I;
                end
            end
            ST_FIRST, ST_SECOND, ST_THIRD, ST_FINAL: begin
                if (play_enable_q) begin
                    if (player_hit) begin
                        // player hit wins over any enemy hit in the same cycle
                        life_lost_d   = 1'b1;
                        play_enable_d = 1'b0;
                        pause_cnt_d   = '0;
                        if (lives_q > LIVES_W'(1)) begin
                            lives_d = LIVES_W'(lives_q - 1'b1);
                        end else begin
                            lives_d     = '0;
                            game_over_d = 1'b1;
                            alive_d     = '0;
                            state_d     = ST_I;
                        end
                    end else begin
                        alive_d = alive_after_hit;
                        if (alive_after_hit == '0) begin
                            round_clear_d = 1'b1;
                            play_enable_d = 1'b0;
                            pause_cnt_d   = '0;
                        end
                    end
                end else begin
                    if (PAUSE_FRAMES == 0) begin
                        pause_done = 1'b1;
                    end else if (frame_tick) begin
                        if (pause_cnt_inc == PAUSE_W'(PAUSE_FRAMES)) begin
                            pause_done = 1'b1;
                        end else begin
                            pause_cnt_d = pause_cnt_inc;
                        end
                    end
                    if (pause_done) begin
                        pause_cnt_d = '0;
                        // an empty alive mask means this pause followed a round clear
                        if (alive_q == '0) begin
                            state_d = next_round;
                            if (next_round != ST_WIN) begin
                                alive_d       = round_mask(next_round);
                                play_enable_d = 1'b1;
                            end
                        end else begin
                            alive_d       = round_mask(state_q);
                            play_enable_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d       = ST_I;
                alive_d       = '0;
                play_enable_d = 1'b0;
                pause_cnt_d   = '0;
            end
        endcase

        enemy_active_d = play_enable_d ? alive_d : '0;
    end

    assign q_I          = state_q[0];
    assign q_First      = state_q[1];
    assign q_Second     = state_q[2];
    assign q_Third      = state_q[3];
    assign q_Final      = state_q[4];
    assign q_Win        = state_q[5];
    assign enemy_active = enemy_active_q;
    assign play_enable  = play_enable_q;
    assign lives        = lives_q;
    assign round_clear  = round_clear_q;
    assign life_lost    = life_lost_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller: directed round walk-through
// followed by randomized play, checked against a round-number game model.
module tb_game_round_controller;

    localparam int unsigned LIVES        = 3;
    localparam int unsigned PAUSE_FRAMES = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       frame_tick;
    logic [3:0] enemy_hit;
    logic       player_hit;
    logic       q_I, q_First, q_Second, q_Third, q_Final, q_Win;
    logic [3:0] enemy_active;
    logic       play_enable;
    logic [1:0] lives;
    logic       round_clear;
    logic       life_lost;
    logic       game_over;

    game_round_controller #(
        .LIVES        (LIVES),
        .PAUSE_FRAMES (PAUSE_FRAMES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_tick   (frame_tick),
        .enemy_hit    (enemy_hit),
        .player_hit   (player_hit),
        .q_I          (q_I),
        .q_First      (q_First),
        .q_Second     (q_Second),
        .q_Third      (q_Third),
        .q_Final      (q_Final),
        .q_Win        (q_Win),
        .enemy_active (enemy_active),
        .play_enable  (play_enable),
        .lives        (lives),
        .round_clear  (round_clear),
        .life_lost    (life_lost),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] st;
        logic [3:0] ea;
        logic       pe;
        logic [1:0] lv;
        logic       rc;
        logic       ll;
        logic       go;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Game model: round 0 = idle, 1..4 = combat rounds, 5 = win
    int         m_round;
    logic [3:0] m_alive;
    bit         m_playing;
    int         m_lives;
    int         m_frames_left;
    bit         m_after_clear;
    bit         m_game_over;
    bit         m_rc;
    bit         m_ll;

    function automatic logic [3:0] mask_of(input int r);
        case (r)
            1:       return 4'b0001;
            2:       return 4'b0010;
            3:       return 4'b1100;
            4:       return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_round = 0; m_alive = 4'b0000; m_playing = 0; m_lives = 0;
        m_frames_left = 0; m_after_clear = 0; m_game_over = 0; m_rc = 0; m_ll = 0;
    endtask

    task automatic model_step(input bit s, input bit t, input logic [3:0] e, input bit p);
        bit resume;
        m_rc = 0; m_ll = 0; resume = 0;
        if (m_round == 0) begin
            if (s) begin
                m_round = 1; m_lives = LIVES; m_alive = mask_of(1);
                m_playing = 1; m_game_over = 0;
            end
        end else if (m_round == 5) begin
            if (s) m_round = 0;
        end else if (m_playing) begin
            if (p) begin
                m_ll = 1;
                m_playing = 0;
                if (m_lives > 1) begin
                    m_lives = m_lives - 1;
                    m_frames_left = PAUSE_FRAMES; m_after_clear = 0;
                end else begin
                    m_lives = 0; m_game_over = 1; m_round = 0; m_alive = 4'b0000;
                end
            end else begin
                m_alive = m_alive & ~e;
                if (m_alive == 4'b0000) begin
                    m_rc = 1; m_playing = 0;
                    m_frames_left = PAUSE_FRAMES; m_after_clear = 1;
                end
            end
        end else begin
            if (m_frames_left == 0) resume = 1;
            else if (t) begin
                m_frames_left = m_frames_left - 1;
                if (m_frames_left == 0) resume = 1;
            end
            if (resume) begin
                if (m_after_clear) begin
                    m_round = m_round + 1;
                    if (m_round < 5) begin
                        m_alive = mask_of(m_round); m_playing = 1;
                    end
                end else begin
                    m_alive = mask_of(m_round); m_playing = 1;
                end
            end
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t x;
        x.st = 6'(1 << m_round);
        x.ea = m_playing ? m_alive : 4'b0000;
        x.pe = m_playing;
        x.lv = 2'(m_lives);
        x.rc = m_rc;
        x.ll = m_ll;
        x.go = m_game_over;
        return x;
    endfunction

    // Apply one cycle of inputs and record the expected post-edge outputs
    task automatic step(input bit s, input bit t, input logic [3:0] e, input bit p);
        @(negedge clk);
        reset = 1'b1; start = s; frame_tick = t; enemy_hit = e; player_hit = p;
        model_step(s, t, e, p);
        exp_q.push_back(model_outputs());
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0; start = 0; frame_tick = 0; enemy_hit = 4'b0000; player_hit = 0;
            model_reset();
            exp_q.push_back(model_outputs());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'b0000, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 4'b0000, 0);
            step(0, 0, 4'b0000, 0);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Monitor: compare DUT outputs after each active edge with the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",        8'({q_Win, q_Final, q_Third, q_Second, q_First, q_I}), 8'(e.st));
                chk("enemy_active", 8'(enemy_active), 8'(e.ea));
                chk("play_enable",  8'(play_enable),  8'(e.pe));
                chk("lives",        8'(lives),        8'(e.lv));
                chk("round_clear",  8'(round_clear),  8'(e.rc));
                chk("life_lost",    8'(life_lost),    8'(e.ll));
                chk("game_over",    8'(game_over),    8'(e.go));
            end
        end
    end

    initial begin
        reset = 1'b0; start = 0; frame_tick = 0; enemy_hit = 4'b0000; player_hit = 0;
        model_reset();
        hold_reset(2);
        idle(2);

        // full round walk-through to Win
        step(1, 0, 4'b0000, 0);
        idle(1);
        step(0, 0, 4'b0001, 0);
        ticks(2);
        step(0, 0, 4'b0010, 0);
        ticks(2);
        step(0, 0, 4'b0100, 0);
        idle(1);
        step(0, 0, 4'b1000, 0);
        ticks(2);
        step(0, 0, 4'b1111, 1);
        ticks(2);
        step(0, 0, 4'b1111, 0);
        ticks(2);
        idle(1);
        step(1, 0, 4'b0000, 0);
        idle(1);

        // lives run-down to game over, including a hit during a pause
        step(1, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 1);
        step(0, 0, 4'b0000, 1);
        ticks(2);
        step(0, 0, 4'b0001, 0);
        ticks(2);
        step(0, 0, 4'b0000, 1);
        ticks(2);
        step(0, 0, 4'b0000, 1);
        idle(2);

        // reset asserted in the middle of a pause in round two
        step(1, 0, 4'b0000, 0);
        step(0, 0, 4'b0001, 0);
        ticks(2);
        step(0, 0, 4'b0000, 1);
        step(0, 1, 4'b0000, 0);
        hold_reset(2);
        idle(1);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                hold_reset(1);
            end else begin
                step(($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                     ($urandom_range(0, 39) == 0));
            end
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
